if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Holds the PC and drives the instruction memory address (Addr); the memory returns Inst combinationally in the same cycle.
- Registers PC+4 and the instruction into the IF/ID pipeline register.
- Computes branch and jump targets from the instruction held in IF/ID, and applies stall, flush and redirect control from the hazard and branch logic.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000000, instruction injected into IF/ID on a flush or reset (sll $0,$0,0).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Inst  in  32  instruction word returned by the instruction memory for Addr.
- Stall  in  1  load-use hazard: hold PC and IF/ID.
- PCSrc  in  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = PC+4 (reserved).
- Addr  out  32  current PC, driven to the instruction memory.
- ID_Inst  out  32  IF/ID instruction register.
- ID_PC4  out  32  IF/ID PC+4 register.
- ID_Valid  out  1  IF/ID holds a real fetched instruction (0 = bubble).
- FetchCount  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Addr = PC register, combinational output. IF_PC4 = PC + 4, with 32-bit wrap-around (32'hFFFFFFFC + 4 = 0).
- BTarget = ID_PC4 + {{14{ID_Inst[15]}}, ID_Inst[15:0], 2'b00}, modulo 2^32.
- JTarget = {ID_PC4[31:28], ID_Inst[25:0], 2'b00}.
- Redirect = (PCSrc == 01) or (PCSrc == 10). The branch/jump resolves in ID.
- Per rising edge, first matching rule wins:
  1. Reset: PC <= RESET_PC; ID_Inst <= NOP_INST; ID_PC4 <= 0; ID_Valid <= 0; FetchCount <= 0.
  2. Stall: PC, ID_Inst, ID_PC4, ID_Valid and FetchCount all hold. PCSrc is ignored, because a stalled ID instruction has not resolved.
  3. Redirect: PC <= BTarget or JTarget. ID_Inst <= NOP_INST, ID_PC4 <= 0, ID_Valid <= 0, so the slot fetched this cycle is squashed. FetchCount holds.
  4. Normal: PC <= IF_PC4; ID_Inst <= Inst; ID_PC4 <= IF_PC4; ID_Valid <= 1; FetchCount <= FetchCount + 1, wrapping at 2^32.
- Redirect penalty is exactly one bubble; there is no delay slot.
- PCSrc = 11 behaves exactly as 00.
- PCSrc is honoured only when ID_Valid = 1. When ID_Valid = 0, it is treated as 00, so a bubble can never redirect.
- Inst is sampled only in rule 4. X on Inst while stalled, redirecting or in reset must not propagate into ID_Inst.
- Reset asserted mid-stall or mid-redirect: rule 1 wins, and the first fetch after release is from RESET_PC.
- Addr is never word-misaligned: the reset value and all targets have bits [1:0] = 0.
- No combinational path exists from Inst to Addr. The paths from PCSrc and Stall to the next PC are combinational; the paths to the outputs are registered.

Test Plan:
- Reset held for 2 cycles, then released, with straight-line code -> Addr sequences 0x00, 0x04, 0x08. ID_Inst = 0x20010008 one cycle after Addr = 0x00. ID_PC4 = 0x04, ID_Valid = 1. FetchCount = 3 after 3 cycles.
- bne 0x14220006 fetched at 0x18, PCSrc = 01 while it is in ID -> next Addr = 0x34. One bubble: ID_Inst = 0, ID_Valid = 0. FetchCount does not increment for the squashed slot.
- J 0x0800000D in ID with ID_PC4 = 0x2C, PCSrc = 10 -> Addr = 0x34, one bubble. Also beq 0x10440002 with ID_PC4 = 0x40, PCSrc = 01 -> Addr = 0x48.
- Stall for 2 cycles while lw 0x8D04000A is in ID, with PCSrc = 01 forced during the stall -> Addr, ID_Inst, ID_PC4 and FetchCount frozen, no redirect. On release, fetching resumes at the held PC.
- PCSrc = 01 with ID_Valid = 0 (the cycle right after a redirect), and separately PCSrc = 11 -> both advance PC by 4.
- Reset asserted in the same cycle as Stall = 1 and PCSrc = 10 -> Addr = RESET_PC, ID_Valid = 0, FetchCount = 0 next cycle. Also PC at 0xFFFFFFFC with a normal step -> Addr = 0x00000000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID pipeline register, applying stall, branch/jump redirect and reset.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Inst,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  output logic [31:0] Addr,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] if_pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        take_branch;
  logic        take_jump;
  logic        redirect;

  assign if_pc4    = pc_q + 32'd4;
  assign br_target = id_pc4_q + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
  assign j_target  = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};

  // A bubble in ID has no branch to resolve, so PCSrc is ignored while it is there.
  assign take_branch = id_valid_q && (PCSrc == 2'b01);
  assign take_jump   = id_valid_q && (PCSrc == 2'b10);
  assign redirect    = take_branch || take_jump;

  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!Stall) begin
      if (redirect) begin
        pc_d       = take_branch ? br_target : j_target;
        id_inst_d  = NOP_INST;
        id_pc4_d   = 32'd0;
        id_valid_d = 1'b0;
      end else begin
        pc_d        = if_pc4;
        id_inst_d   = Inst;
        id_pc4_d    = if_pc4;
        id_valid_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q        <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_pc4_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign Addr       = pc_q;
  assign ID_Inst    = id_inst_q;
  assign ID_PC4     = id_pc4_q;
  assign ID_Valid   = id_valid_q;
  assign FetchCount = fetch_cnt_q;

endmodule
